// File: rtl/data_sync_tx_sched_pkg.sv
// Shared types for the source-side synchronizer scheduler: FSM states and
// the sizing helper for the enable/hold down-counter.
package data_sync_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Counter loads at most max(e,h)-1; never narrower than one bit.
  function automatic int cnt_width(int e, int h);
    int m;
    m = (e > h) ? e : h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/data_sync_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request after 'last', wrapping
// modulo NUM_REQ, reported as one-hot, index and a valid flag.
module data_sync_tx_sched_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    onehot = '0;
    id     = '0;
    found  = 1'b0;
    idx    = '0;
    // Offsets 1..NUM_REQ so 'last' itself is visited only after everyone else.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        onehot[idx] = 1'b1;
        id          = idx;
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/data_sync_tx_sched.sv
// Round-robin scheduler feeding one shared bus synchronizer: launches a word
// with bus_enable for ENABLE_CYCLES, then holds it HOLD_CYCLES to settle.
module data_sync_tx_sched
  import data_sync_tx_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int BUS_WIDTH     = 8,
  parameter int ENABLE_CYCLES = 1,
  parameter int HOLD_CYCLES   = 6,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic [ID_W-1:0]              src_id,
  output logic                         busy
);

  localparam int CNT_W = cnt_width(ENABLE_CYCLES, HOLD_CYCLES);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]     grant_d;
  logic [BUS_WIDTH-1:0]   bus_d;
  logic                   en_d;
  logic [ID_W-1:0]        src_d;

  logic [NUM_REQ-1:0]     arb_onehot;
  logic [ID_W-1:0]        arb_id;
  logic                   arb_valid;

  data_sync_tx_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .last   (last_q),
    .onehot (arb_onehot),
    .id     (arb_id),
    .valid  (arb_valid)
  );

  // req is only looked at in IDLE; the word is captured on the launch edge
  // and the bus is left untouched until the next launch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = '0;
    bus_d   = unsync_bus;
    en_d    = bus_enable;
    src_d   = src_id;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = LAUNCH;
          bus_d   = req_data[int'(arb_id)*BUS_WIDTH +: BUS_WIDTH];
          en_d    = 1'b1;
          grant_d = arb_onehot;
          src_d   = arb_id;
          last_d  = arb_id;
          cnt_d   = CNT_W'(ENABLE_CYCLES - 1);
        end
      end
      LAUNCH: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      grant      <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      src_id     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant      <= grant_d;
      unsync_bus <= bus_d;
      bus_enable <= en_d;
      src_id     <= src_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_data_sync_tx_sched.sv
// Two scheduler instances (default timing and ENABLE=3/HOLD=2) driven with the
// same requester traffic and checked against a time-budget reference model.
module tb_data_sync_tx_sched;

  localparam int NR = 4;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req        [2];
  logic [NR*BW-1:0] req_data  [2];
  logic [NR-1:0]   grant      [2];
  logic [BW-1:0]   unsync_bus [2];
  logic            bus_enable [2];
  logic [1:0]      src_id     [2];
  logic            busy       [2];

  always #5 clk = ~clk;

  data_sync_tx_sched #(.NUM_REQ(NR), .BUS_WIDTH(BW), .ENABLE_CYCLES(1), .HOLD_CYCLES(6)) dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .req_data(req_data[0]), .grant(grant[0]),
    .unsync_bus(unsync_bus[0]), .bus_enable(bus_enable[0]), .src_id(src_id[0]), .busy(busy[0])
  );

  data_sync_tx_sched #(.NUM_REQ(NR), .BUS_WIDTH(BW), .ENABLE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .req_data(req_data[1]), .grant(grant[1]),
    .unsync_bus(unsync_bus[1]), .bus_enable(bus_enable[1]), .src_id(src_id[1]), .busy(busy[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] exp_q[$];  // {lane, id, word}

  task automatic chk(string name, int lane, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, lane, act, exp, $time);
  endtask

  function automatic int en_cycles(int lane);
    return (lane == 0) ? 1 : 3;
  endfunction

  function automatic int hold_cycles(int lane);
    return (lane == 0) ? 6 : 2;
  endfunction

  // ---------------- reference model ----------------
  // A transfer occupies the scheduler for ENABLE+HOLD cycles after its launch
  // edge; a new winner can only be chosen once that budget has run out.
  int          m_left [2];
  int          m_en   [2];
  int          m_last [2];
  logic [NR-1:0] e_grant [2];
  logic [BW-1:0] e_bus   [2];
  logic [1:0]    e_src   [2];
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_ok = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_left[k] = 0; m_en[k] = 0; m_last[k] = NR - 1;
        e_grant[k] = '0; e_bus[k] = '0; e_src[k] = '0;
      end else begin
        e_grant[k] = '0;
        if (m_left[k] == 0) begin
          if (req[k] != '0) begin
            int w;
            w = -1;
            for (int j = 1; j <= NR; j++) begin
              int c;
              c = (m_last[k] + j) % NR;
              if (w < 0 && req[k][c]) w = c;
            end
            m_last[k]  = w;
            m_left[k]  = en_cycles(k) + hold_cycles(k);
            m_en[k]    = en_cycles(k);
            e_grant[k] = NR'(1) << w;
            e_bus[k]   = req_data[k][w*BW +: BW];
            e_src[k]   = 2'(w);
            exp_q.push_back({k[0], 2'(w), req_data[k][w*BW +: BW]});
          end
        end else begin
          m_left[k]--;
          if (m_en[k] > 0) m_en[k]--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk("grant", k, 32'(grant[k]), 32'(e_grant[k]));
        chk("bus_enable", k, 32'(bus_enable[k]), 32'(m_en[k] > 0));
        chk("busy", k, 32'(busy[k]), 32'(m_left[k] > 0));
        chk("unsync_bus", k, 32'(unsync_bus[k]), 32'(e_bus[k]));
        chk("src_id", k, 32'(src_id[k]), 32'(e_src[k]));
        if (grant[k] != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", k, 32'(grant[k]), 32'h0);
          end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            chk("sb_transfer", k, {21'h0, k[0], src_id[k], unsync_bus[k]}, {21'h0, e});
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  bit keep_all = 1'b0;
  bit rand_on  = 1'b0;

  // Requesters drop req on their grant; keep_all re-raises everything each cycle.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (keep_all) req[k] = '1;
      else req[k] = req[k] & ~grant[k];
      if (rand_on) begin
        for (int i = 0; i < NR; i++) begin
          if (!req[k][i] && $urandom_range(0, 3) == 0) begin
            req[k][i] = 1'b1;
            req_data[k][i*BW +: BW] = 8'($urandom_range(0, 255));
          end else if (req[k][i] && !grant[k][i] && $urandom_range(0, 15) == 0) begin
            req[k][i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic set_word(int i, logic [BW-1:0] v);
    for (int k = 0; k < 2; k++) req_data[k][i*BW +: BW] = v;
  endtask

  task automatic set_req(logic [NR-1:0] r);
    for (int k = 0; k < 2; k++) req[k] = r;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = '0;
      req_data[k] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;

    // single request on index 2
    tick();
    set_word(2, 8'h11);
    set_req(4'b0100);
    repeat (14) tick();

    // all four held: A0..A3 in rr order, then drain
    set_word(0, 8'hA0); set_word(1, 8'hA1); set_word(2, 8'hA2); set_word(3, 8'hA3);
    keep_all = 1'b1;
    repeat (45) tick();
    keep_all = 1'b0;
    repeat (40) tick();

    // wrap and skip: make last=3, then 1010 -> 1 then 3
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    set_word(3, 8'hC3);
    set_req(4'b1000);
    repeat (10) tick();
    set_word(1, 8'hC1);
    set_req(4'b1010);
    repeat (20) tick();

    // request raised during HOLD of another transfer
    set_word(0, 8'hD0);
    set_req(4'b0001);
    repeat (4) tick();
    set_word(3, 8'hDA);
    for (int k = 0; k < 2; k++) req[k][3] = 1'b1;
    repeat (20) tick();

    // reset in the middle of a launch, all requesters pending
    set_word(0, 8'hE0); set_word(1, 8'hE1); set_word(2, 8'hE2); set_word(3, 8'hE3);
    keep_all = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    keep_all = 1'b0;
    repeat (40) tick();

    // random traffic
    rand_on = 1'b1;
    repeat (600) tick();
    rand_on = 1'b0;
    repeat (50) tick();

    chk("sb_drained", 0, 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_sync_tx_sched.md
Name: data_sync_tx_sched

Overview:
- Source-domain scheduler that shares one multi-flop bus synchronizer crossing between NUM_REQ requesters.
- Picks a requester round-robin and loads its word onto unsync_bus.
- Pulses bus_enable for ENABLE_CYCLES, then holds unsync_bus stable for HOLD_CYCLES so the destination-side synchronizer captures a settled word.
- Returns a one-cycle grant to the winner. Sits directly upstream of the synchronizer's unsync_bus/bus_enable inputs.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- BUS_WIDTH, 8, data word width; matches synchronizer BUS_WIDTH.
- ENABLE_CYCLES, 1, cycles bus_enable is held high per transfer (>=1).
- HOLD_CYCLES, 6, cycles unsync_bus is held stable after bus_enable falls (>=1). Sized by integration for dest NUM_STAGES and clock ratio.
- ID_W, $clog2(NUM_REQ), requester index width (derived localparam).

Ports:
- clk  in  1  source-domain clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until matching grant seen.
- req_data  in  NUM_REQ*BUS_WIDTH  packed words; requester i at bits [i*BUS_WIDTH +: BUS_WIDTH]; stable while req[i]=1.
- grant  out  NUM_REQ  one-hot, one-cycle acceptance pulse, registered.
- unsync_bus  out  BUS_WIDTH  word to synchronizer, registered.
- bus_enable  out  1  enable to synchronizer, registered.
- src_id  out  ID_W  index of last granted requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE; grant=0, unsync_bus=0, bus_enable=0, src_id=0, busy=0; rr pointer last=NUM_REQ-1, so req[0] wins first. Reset overrides all transitions, including mid-transfer; bus_enable drops on that edge.
- States: IDLE, LAUNCH, HOLD.
- IDLE, no req: all outputs hold; unsync_bus keeps its last value, never cleared.
- IDLE, any req at edge:
  - Winner w is the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - At the edge: unsync_bus<=req_data[w], bus_enable<=1, grant<=onehot(w), src_id<=w, last<=w, cnt<=ENABLE_CYCLES-1, state->LAUNCH.
- LAUNCH:
  - grant returns to 0 after its single cycle.
  - bus_enable stays 1 while cnt>0; cnt decrements each cycle.
  - At cnt==0: bus_enable<=0, cnt<=HOLD_CYCLES-1, state->HOLD.
- HOLD: unsync_bus unchanged; cnt decrements; at cnt==0 state->IDLE.
- Timing:
  - Latency req-sampled-edge to bus_enable high: 1 cycle.
  - bus_enable is high exactly ENABLE_CYCLES cycles.
  - Minimum spacing between bus_enable rising edges: ENABLE_CYCLES+HOLD_CYCLES+1 cycles (8 with defaults).
- req is ignored outside IDLE. Requesters keep req high until grant; a req dropped before grant is simply not served.
- Simultaneous requests: exactly one grant; grant never has more than one bit set.
- A requester re-asserting immediately after its grant is served only after the others pending in rr order.
- Pointer wrap: last=NUM_REQ-1 wraps search to index 0.
- unsync_bus changes only on the IDLE->LAUNCH edge (or reset). It is never altered while bus_enable=1 or in HOLD.

Decomposition:
- Shared package: state enum (IDLE, LAUNCH, HOLD) and counter width localparam, $clog2(max(ENABLE_CYCLES,HOLD_CYCLES)).
- Sub-module rr_arbiter: combinational round-robin pick from req and last, outputting one-hot plus index and a valid flag.
- Pointer register and FSM stay in data_sync_tx_sched.

Test Plan:
- Reset: assert reset 2 cycles mid-LAUNCH -> next edge bus_enable=0, unsync_bus=0, grant=0, busy=0; first grant after release goes to req[0] when all req set.
- Single request: req=4'b0100, data[2]=8'h11 -> grant=4'b0100 for 1 cycle; unsync_bus=8'h11 with bus_enable=1 for exactly 1 cycle; busy high 7 cycles; unsync_bus stays 8'h11 afterwards.
- Round-robin: all four req held with data 8'hA0..8'hA3 -> grants in order 0,1,2,3,0; bus_enable rises every 8 cycles; unsync_bus sequence A0,A1,A2,A3,A0.
- Wrap and skip: last=3, req=4'b1010 -> grant index 1, then 3; src_id follows 1,3.
- Mid-transfer request: req[3] asserted during HOLD of req[0] -> no grant until IDLE; bus_enable stays 0 in HOLD; unsync_bus unchanged until the new launch edge.
- Params ENABLE_CYCLES=3, HOLD_CYCLES=2 -> bus_enable high 3 cycles; rising edges spaced 6 cycles under continuous req.
